svm_decision_accum: RTL
=======================

// Module: svm_decision_accum
// PURPOSE
//  Downstream of the HWF kernel stage in one cascade level. Consumes one kernel value K(x,sv_i)
//  per support vector and multiply-accumulates alpha_i*y_i*K over NUM_SV vectors, starting from bias b.
//  Classifies the sum against two thresholds:
//    - confident positive
//    - confident negative
//    - uncertain (the next cascade stage takes the sample).
//  Valid/ready on input and output; one decision per frame of NUM_SV kernel beats.
// PARAMETERS
//  XLEN_PIXEL  8   width of signed kernel value k_val
//  XLEN_ALPHA  8   width of signed coefficient alpha (alpha_i*y_i, pre-folded)
//  NUM_SV      16  support vectors per frame (>=1)
//  ACC_W       24  signed accumulator/bias/threshold width (>= XLEN_PIXEL+XLEN_ALPHA)
// PORTS
//  clk      in   1           clock, rising edge
//  rst      in   1           synchronous, active-high reset
//  k_valid  in   1           kernel beat valid
//  k_ready  out  1           block can accept a kernel beat
//  k_val    in   XLEN_PIXEL  signed kernel value (Ei_next of the kernel stage)
//  alpha    in   XLEN_ALPHA  signed coefficient paired with k_val
//  bias     in   ACC_W       signed bias, sampled with first beat of a frame
//  thr_pos  in   ACC_W       signed positive-accept threshold
//  thr_neg  in   ACC_W       signed negative-accept threshold
//  d_valid  out  1           decision valid
//  d_ready  in   1           consumer accepts decision
//  d_sum    out  ACC_W       saturated decision value
//  d_class  out  2           01 positive, 10 negative, 00 uncertain (forward), 11 never
//  d_sat    out  1           saturation occurred anywhere in this frame
//  sv_idx   out  clog2(NUM_SV+1)  beats accepted in current frame
// BEHAVIOUR
//  Reset: state IDLE, acc=0, sv_idx=0, d_valid=0, d_sum=0, d_class=00, d_sat=0; k_ready=0 while rst high.
//  Beat accepted on rising edge with k_valid & k_ready. k_ready = 1 in IDLE/ACCUM, 0 in DECIDE/HOLD.
//  FSM:
//    - IDLE: on beat, acc <= sat(bias + p), sv_idx=1, sat flag reset to overflow of this add;
//      -> DECIDE if NUM_SV==1, else ACCUM.
//    - ACCUM: on beat, acc <= sat(acc + p), sv_idx++; beat making sv_idx==NUM_SV -> DECIDE.
//      No beat: hold everything (gaps in k_valid allowed).
//    - DECIDE (1 cycle): register d_sum=acc, d_class, d_sat; set d_valid -> HOLD.
//    - HOLD: outputs stable while d_valid & !d_ready.
//      On d_valid & d_ready: d_valid=0, sv_idx=0 -> IDLE. Next beat accepted from the following cycle.
//  Latency: d_valid rises at 2nd rising edge after the edge accepting the NUM_SV-th beat.
//  Arithmetic:
//    - p = k_val*alpha, full signed product (XLEN_PIXEL+XLEN_ALPHA bits), sign-extended to ACC_W.
//    - Every add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//    - Saturation is sticky into d_sat; accumulation continues from the clamped value.
//  Classification (thresholds sampled in DECIDE):
//    - d_sum >= thr_pos -> 01
//    - else d_sum <= thr_neg -> 10
//    - else 00
//    - Overlapping thresholds: positive wins.
//  Reset mid-frame or mid-HOLD: partial sum and pending decision discarded, no d_valid; returns to reset state.
//  Extra beats offered during DECIDE/HOLD are not consumed (k_ready=0); upstream must hold them.
// TESTING
//  1. NUM_SV=4, bias=0, k=10,20,30,40, alpha=1, thr_pos=50, thr_neg=-50
//       -> d_sum=100, d_class=01, d_sat=0, d_valid 2 edges after 4th beat.
//  2. bias=5, k=10 x4, alpha=-2, thr_neg=-50 -> d_sum=-75, d_class=10.
//  3. k=5,-5,5,-5, alpha=1, bias=0, thr_pos=10, thr_neg=-10 -> d_sum=0, d_class=00.
//  4. ACC_W=16, bias=32767, k=127, alpha=127 x4 -> d_sum=32767, d_sat=1; next frame d_sat=0.
//  5. k_valid gaps of 3 cycles between beats, d_ready low 5 cycles
//       -> same sum as gap-free; d_valid/d_sum/d_class stable; k_ready=0 throughout HOLD;
//          next frame starts after handshake.
//  6. rst pulsed after 2 beats, then full frame k=1 x4, alpha=1, bias=0
//       -> no decision from aborted frame; d_sum=4.

Source files
------------

// File: rtl/svm_decision_accum.sv
// SVM decision accumulator for one cascade level.
// Consumes NUM_SV kernel beats per frame and multiply-accumulates alpha*K on top of the bias.
// Every add saturates, and any saturation is remembered for the whole frame.
// The final sum is classified as confident positive, confident negative or uncertain.
// An uncertain result is forwarded to the next cascade stage.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | waiting for the first beat of a frame; bias is folded in here
//  ACCUM  | accumulating beats 2..NUM_SV, gaps in k_valid simply hold state
//  DECIDE | one cycle: register sum, class and saturation flag
//  HOLD   | decision presented until the consumer takes it
module svm_decision_accum #(
  parameter int XLEN_PIXEL = 8,
  parameter int XLEN_ALPHA = 8,
  parameter int NUM_SV     = 16,
  parameter int ACC_W      = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               k_valid,
  output logic                               k_ready,
  input  logic signed [XLEN_PIXEL-1:0]       k_val,
  input  logic signed [XLEN_ALPHA-1:0]       alpha,
  input  logic signed [ACC_W-1:0]            bias,
  input  logic signed [ACC_W-1:0]            thr_pos,
  input  logic signed [ACC_W-1:0]            thr_neg,
  output logic                               d_valid,
  input  logic                               d_ready,
  output logic signed [ACC_W-1:0]            d_sum,
  output logic [1:0]                         d_class,
  output logic                               d_sat,
  output logic [$clog2(NUM_SV+1)-1:0]        sv_idx
);

  localparam int PW    = XLEN_PIXEL + XLEN_ALPHA;
  localparam int IDX_W = $clog2(NUM_SV + 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE, S_HOLD} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic                    sat_q;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_a;
  logic signed [ACC_W:0]   sum_wide;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] sum_sat;
  logic                    beat;

  // Full-width signed product; the first beat of a frame adds onto the bias instead of acc.
  assign prod     = k_val * alpha;
  assign prod_ext = ACC_W'(prod);
  assign add_a    = (state == S_IDLE) ? bias : acc;
  assign sum_wide = (ACC_W+1)'(add_a) + (ACC_W+1)'(prod_ext);
  assign add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  assign k_ready = !rst && ((state == S_IDLE) || (state == S_ACCUM));
  assign beat    = k_valid && k_ready;

  // Clamp the widened sum to the accumulator range; the extra MSB tells the overflow direction.
  always_comb begin
    sum_sat = sum_wide[ACC_W-1:0];
    if (add_ovf) begin
      sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Frame sequencing, accumulation and registered decision outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      sat_q   <= 1'b0;
      sv_idx  <= '0;
      d_valid <= 1'b0;
      d_sum   <= '0;
      d_class <= 2'b00;
      d_sat   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (beat) begin
            acc    <= sum_sat;
            sat_q  <= add_ovf;
            sv_idx <= IDX_W'(1);
            state  <= (NUM_SV == 1) ? S_DECIDE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc    <= sum_sat;
            sat_q  <= sat_q | add_ovf;
            sv_idx <= sv_idx + IDX_W'(1);
            if (sv_idx == IDX_LAST) begin
              state <= S_DECIDE;
            end
          end
        end
        S_DECIDE: begin
          d_sum   <= acc;
          d_sat   <= sat_q;
          d_valid <= 1'b1;
          // Positive threshold is tested first so overlapping thresholds resolve positive.
          if (acc >= thr_pos) begin
            d_class <= 2'b01;
          end else if (acc <= thr_neg) begin
            d_class <= 2'b10;
          end else begin
            d_class <= 2'b00;
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (d_ready) begin
            d_valid <= 1'b0;
            sv_idx  <= '0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
